// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and a multi-cycle
// MADDU hold, with saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             en_reg,
    output logic             mul_start,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_MADDU = 6'd28;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [3:0]       mcnt_r, mcnt_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
    logic             id_uses_rt_s, load_use_s;

    // Decode which ID instructions actually read rt, then detect load-use.
    always_comb begin
        id_uses_rt_s = 1'b0;
        case (id_opcode)
            OP_R, OP_MADDU, OP_SW, OP_BEQ: id_uses_rt_s = 1'b1;
            default:                       id_uses_rt_s = 1'b0;
        endcase
        load_use_s = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || ((ex_rt == id_rt) && id_uses_rt_s));
    end

    // Next-state and combinational pipeline control, in priority order.
    always_comb begin
        state_nxt_s = state_r;
        mcnt_nxt_s  = mcnt_r;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        mul_start   = 1'b0;
        mul_busy    = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            state_nxt_s = IDLE;
            mcnt_nxt_s  = 4'd0;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            mul_busy    = (state_r == MUL);
            state_nxt_s = IDLE;
            mcnt_nxt_s  = 4'd0;
        end else begin
            case (state_r)
                MUL: begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                    mul_busy   = 1'b1;
                    mcnt_nxt_s = mcnt_r - 4'd1;
                    if (mcnt_r == 4'd1) begin
                        state_nxt_s = RELEASE;
                    end else begin
                        state_nxt_s = MUL;
                    end
                end
                // ID still holds the MADDU whose operands were already checked.
                RELEASE: begin
                    state_nxt_s = IDLE;
                end
                IDLE: begin
                    if (load_use_s) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (id_opcode == OP_MADDU) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_flush  = 1'b1;
                        mul_start   = 1'b1;
                        mul_busy    = 1'b1;
                        mcnt_nxt_s  = MCNT_INIT;
                        state_nxt_s = MUL;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    mcnt_nxt_s  = 4'd0;
                end
            endcase
        end
    end

    assign en_reg    = !idex_flush;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // State, multiplier countdown and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mcnt_r      <= 4'd0;
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            mcnt_r  <= mcnt_nxt_s;
            if (!pc_en && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (ifid_flush && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a cycle-level model compared every cycle,
// plus directed scenarios with hand-computed pinned values.
module tb_pipeline_hazard_ctrl;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [5:0] R = 6'd0, MADDU = 6'd28, ADDIU = 6'd9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] id_opcode = 6'd0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
    logic ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic pc_en, ifid_en, ifid_flush, idex_flush, en_reg, mul_start, mul_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    // Model: how many further MUL-hold cycles remain, and whether a release is due.
    int hold_left = 0;
    bit rel_due = 1'b0;
    int m_stall = 0, m_flush = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .en_reg(en_reg), .mul_start(mul_start),
        .mul_busy(mul_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) started <= 1'b1;

    // Per-cycle comparison against the model, then model advance for the coming edge.
    always @(negedge clk) begin
        if (started) begin
            automatic bit reads_rt = (id_opcode == 6'd0) || (id_opcode == 6'd28) ||
                                     (id_opcode == 6'd43) || (id_opcode == 6'd4);
            automatic bit lu = ex_memread && ex_rt != 0 &&
                               (ex_rt == id_rs || (ex_rt == id_rt && reads_rt));
            automatic bit e_pc = 1, e_iff = 0, e_idf = 0, e_ms = 0, e_busy = 0;
            automatic logic [8:0] exp_v, act_v;
            if (rst) begin
                e_pc = 0; e_iff = 1; e_idf = 1;
            end else if (ex_branch_taken) begin
                e_iff = 1; e_idf = 1; e_busy = (hold_left > 0);
            end else if (hold_left > 0) begin
                e_pc = 0; e_idf = 1; e_busy = 1;
            end else if (rel_due) begin
                e_pc = 1;
            end else if (lu) begin
                e_pc = 0; e_idf = 1;
            end else if (id_opcode == MADDU) begin
                e_pc = 0; e_idf = 1; e_ms = 1; e_busy = 1;
            end
            exp_v = {e_pc, e_pc, e_iff, e_idf, ~e_idf, e_ms, e_busy, 2'b00};
            act_v = {pc_en, ifid_en, ifid_flush, idex_flush, en_reg, mul_start, mul_busy, 2'b00};
            checks++;
            if (exp_v !== act_v || stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
                failures++;
                $display("FAIL model t=%0t ctl act=%b exp=%b stall act=%0d exp=%0d flush act=%0d exp=%0d",
                         $time, act_v, exp_v, stall_cnt, m_stall, flush_cnt, m_flush);
            end
            if (rst) begin
                hold_left = 0; rel_due = 0; m_stall = 0; m_flush = 0;
            end else begin
                if (!e_pc && m_stall < CNT_MAX) m_stall++;
                if (e_iff && m_flush < CNT_MAX) m_flush++;
                if (ex_branch_taken) begin
                    hold_left = 0; rel_due = 0;
                end else if (hold_left > 0) begin
                    hold_left--;
                    rel_due = (hold_left == 0);
                end else if (rel_due) begin
                    rel_due = 0;
                end else if (e_ms) begin
                    hold_left = MUL_LAT - 1;
                end
            end
        end
    end

    task automatic pin(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs just after the edge; return after the opposite edge.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                       input logic br);
        @(posedge clk); #1;
        rst = r; id_opcode = op; id_rs = rs; id_rt = rt;
        ex_memread = mr; ex_rt = ert; ex_branch_taken = br;
        @(negedge clk); #1;
    endtask

    initial begin
        // Reset held with a MADDU waiting in ID
        cyc(1, MADDU, 1, 2, 0, 0, 0);
        cyc(1, MADDU, 1, 2, 0, 0, 0);
        pin("rst_pc_en", pc_en, 0);
        pin("rst_ifid_flush", ifid_flush, 1);
        pin("rst_en_reg", en_reg, 0);
        pin("rst_mul_start", mul_start, 0);
        pin("rst_mul_busy", mul_busy, 0);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("post_rst_pc_en", pc_en, 1);
        pin("post_rst_idex_flush", idex_flush, 0);
        pin("post_rst_stall_cnt", stall_cnt, 0);

        // Load-use on rt of an R-type
        cyc(0, R, 1, 5, 1, 5, 0);
        pin("lu_pc_en", pc_en, 0);
        pin("lu_en_reg", en_reg, 0);
        cyc(0, R, 1, 5, 0, 5, 0);
        pin("lu_clear_pc_en", pc_en, 1);
        pin("lu_stall_cnt", stall_cnt, 1);

        // No hazard: r0 destination, or ADDIU not reading rt
        cyc(0, R, 1, 0, 1, 0, 0);
        pin("r0_pc_en", pc_en, 1);
        cyc(0, ADDIU, 1, 5, 1, 5, 0);
        pin("addiu_pc_en", pc_en, 1);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("nolu_stall_cnt", stall_cnt, 1);

        // Full MADDU sequence; load-use during RELEASE must be ignored
        cyc(0, MADDU, 3, 4, 0, 0, 0);
        pin("madd_c0_start", mul_start, 1);
        pin("madd_c0_pc_en", pc_en, 0);
        for (int i = 1; i < MUL_LAT; i++) begin
            cyc(0, MADDU, 3, 4, 0, 0, 0);
            pin("madd_hold_pc_en", pc_en, 0);
            pin("madd_hold_start", mul_start, 0);
        end
        cyc(0, MADDU, 3, 4, 1, 3, 0);
        pin("release_pc_en", pc_en, 1);
        pin("release_idex_flush", idex_flush, 0);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("madd_stall_cnt", stall_cnt, 5);

        // Branch in the second MUL cycle aborts the sequence
        cyc(0, MADDU, 3, 4, 0, 0, 0);
        cyc(0, MADDU, 3, 4, 0, 0, 0);
        cyc(0, MADDU, 3, 4, 0, 0, 1);
        pin("abort_ifid_flush", ifid_flush, 1);
        pin("abort_idex_flush", idex_flush, 1);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("abort_mul_busy", mul_busy, 0);
        pin("abort_pc_en", pc_en, 1);
        pin("abort_flush_cnt", flush_cnt, 1);

        // Load-use and branch together: branch wins
        cyc(0, R, 5, 1, 1, 5, 1);
        pin("lubr_pc_en", pc_en, 1);
        pin("lubr_ifid_flush", ifid_flush, 1);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("lubr_stall_cnt", stall_cnt, 7);
        pin("lubr_flush_cnt", flush_cnt, 2);

        // MADDU with load-use: stall first, start next cycle
        cyc(0, MADDU, 6, 4, 1, 6, 0);
        pin("maddlu_start", mul_start, 0);
        pin("maddlu_pc_en", pc_en, 0);
        cyc(0, MADDU, 6, 4, 0, 6, 0);
        pin("maddlu_start_next", mul_start, 1);
        for (int i = 0; i < MUL_LAT; i++) cyc(0, MADDU, 6, 4, 0, 0, 0);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("maddlu_stall_cnt", stall_cnt, 12);

        // Reset in the middle of MUL
        cyc(0, MADDU, 3, 4, 0, 0, 0);
        cyc(0, MADDU, 3, 4, 0, 0, 0);
        cyc(1, MADDU, 3, 4, 0, 0, 0);
        cyc(1, ADDIU, 3, 4, 0, 0, 0);
        cyc(0, ADDIU, 3, 4, 0, 0, 0);
        pin("midrst_mul_start", mul_start, 0);
        pin("midrst_pc_en", pc_en, 1);
        pin("midrst_stall_cnt", stall_cnt, 0);
        pin("midrst_flush_cnt", flush_cnt, 0);

        // Counter saturation
        for (int i = 0; i < CNT_MAX + 3; i++) cyc(0, R, 7, 1, 1, 7, 0);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("stall_sat", stall_cnt, CNT_MAX);
        for (int i = 0; i < CNT_MAX + 3; i++) cyc(0, ADDIU, 1, 2, 0, 0, 1);
        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        pin("flush_sat", flush_cnt, CNT_MAX);
        pin("stall_sat_hold", stall_cnt, CNT_MAX);

        cyc(0, ADDIU, 1, 2, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The module SHALL have parameter MUL_LAT, default 4, giving the number of multiplier busy cycles for MADDU (legal range 2..15).
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of the stall and flush event counters.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_opcode  input  6  opcode of the instruction in ID.
REQ-006 id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-007 ex_memread  input  1  the instruction in EX is a LW.
REQ-008 ex_rt  input  5  destination register of the LW in EX.
REQ-009 ex_branch_taken  input  1  a BEQ or J in EX redirects the PC this cycle.
REQ-010 pc_en  output  1  PC load enable.
REQ-011 ifid_en  output  1  IF/ID register load enable.
REQ-012 ifid_flush  output  1  clears IF/ID to NOP at the next edge.
REQ-013 idex_flush  output  1  inserts a bubble into ID/EX.
REQ-014 en_reg  output  1  enable to the control unit; 0 forces all control signals to 0.
REQ-015 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-016 mul_busy  output  1  the multiplier sequence is in progress.
REQ-017 stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-018 State machine states SHALL be IDLE, MUL and RELEASE, with a registered down-counter mcnt of 4 bits.
REQ-019 Opcode decode SHALL be: R=0, MADDU=28, ADDIU=9, LW=35, SW=43, BEQ=4, J=2.
REQ-020 id_uses_rt SHALL be 1 for opcodes R, MADDU, SW and BEQ, and 0 otherwise.
REQ-021 load_use SHALL be asserted when ex_memread=1, ex_rt!=0, and either ex_rt==id_rs or (ex_rt==id_rt and id_uses_rt=1).
REQ-022 Control outputs SHALL be combinational from state and inputs, and counters SHALL be registered.
REQ-023 Priority SHALL be, highest first: rst, ex_branch_taken, state MUL, load_use, MADDU start.
REQ-024 When ex_branch_taken=1:
- pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
- Any MUL sequence SHALL be aborted and the next state SHALL be IDLE.
- mul_start=0.
REQ-025 In state MUL without a branch:
- pc_en=0, ifid_en=0, idex_flush=1.
- mcnt SHALL decrement each cycle.
- When mcnt==1, the next state SHALL be RELEASE.
REQ-026 In state RELEASE:
- pc_en=1, ifid_en=1, idex_flush=0, so the held MADDU advances to EX.
- The next state SHALL be IDLE.
- A load_use in this cycle SHALL be ignored, because the ID operands belong to the already-checked MADDU.
REQ-027 In state IDLE with load_use and no branch:
- pc_en=0, ifid_en=0, idex_flush=1 for exactly that cycle.
- After the bubble, ex_memread drops and the condition clears.
REQ-028 In state IDLE with id_opcode=MADDU, no load_use and no branch:
- mul_start=1, pc_en=0, ifid_en=0, idex_flush=1.
- Load mcnt=MUL_LAT-1 and set the next state to MUL.
- Total hold of MADDU in ID SHALL be MUL_LAT cycles, followed by the RELEASE cycle.
REQ-029 A MADDU that also has a load_use SHALL first take the load-use stall, and SHALL start the multiplier in the following cycle.
REQ-030 Default outputs SHALL be pc_en=1, ifid_en=1, ifid_flush=0, idex_flush=0, mul_start=0.
REQ-031 en_reg SHALL equal !idex_flush at all times.
REQ-032 mul_busy SHALL be 1 in states MUL and in the mul_start cycle, and 0 otherwise.
REQ-033 stall_cnt SHALL increment on every cycle with pc_en=0, and SHALL saturate at all-ones.
REQ-034 flush_cnt SHALL increment on every cycle with ifid_flush=1, and SHALL saturate at all-ones.

Reset
REQ-035 While rst=1, the outputs SHALL be:
- pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, en_reg=0.
- mul_start=0, mul_busy=0.
REQ-036 While rst=1, at each edge: state=IDLE, mcnt=0, stall_cnt=0, flush_cnt=0.
REQ-037 rst asserted mid-MUL SHALL abort the sequence within the same edge, with no mul_start on release.
REQ-038 In the first cycle after rst falls, the outputs SHALL take their REQ-030 default values.

Verification
REQ-039 LW into r5 in EX (ex_memread=1, ex_rt=5), with ID R-type id_rt=5 -> one cycle of pc_en=0 and en_reg=0; stall_cnt 0->1.
REQ-040 Same as REQ-039 but ex_rt=0, or ID is ADDIU with id_rt=5 -> no stall; stall_cnt stays 0.
REQ-041 MADDU in ID, MUL_LAT=4 -> mul_start pulses in cycle 0; pc_en=0 in cycles 0-3; pc_en=1 and idex_flush=0 in cycle 4 (RELEASE); stall_cnt=4.
REQ-042 ex_branch_taken=1 in the 2nd MUL cycle -> ifid_flush=1 and idex_flush=1 that cycle; state IDLE next cycle; mul_busy=0; flush_cnt=1.
REQ-043 load_use and ex_branch_taken asserted together -> pc_en=1 and both flushes=1; stall_cnt unchanged.
REQ-044 rst raised during MUL, then released with a non-MADDU in ID -> all counters 0; no mul_start; first post-reset cycle has pc_en=1.
